// File: rtl/traceback_pipe.sv
`default_nettype none
// ============================================================================
// Module   : traceback_pipe
// Purpose  : Viterbi traceback unit. Walks the trellis backwards through the
//            decision memory one step per cycle, skips the training steps and
//            packs the decoded bits into words on a valid/ready stream.
// Ports    : clk_i, rst_sync_i         - clock, synchronous active-high reset
//            start_i + config inputs   - segment launch (sampled when idle)
//            busy_o, start_err_o       - status
//            tb_rd_o/tb_addr_o/tb_rdata_i - decision memory read port
//            out_* / out_ready_i       - packed decoded-bit output stream
// Revision : 1.0 - initial release
// ============================================================================
module traceback_pipe #(
    parameter int W_STATE = 6,
    parameter int W_ABITS = 3,
    parameter int W_ADDR  = 6,
    parameter int W_LEN   = 7,
    parameter int W_OUT   = 32,
    parameter int W_CNT   = 6,
    parameter int RD_LAT  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_sync_i,
    input  logic                    start_i,
    input  logic [W_STATE-1:0]      start_state_i,
    input  logic [W_ABITS-1:0]      active_bits_i,
    input  logic [W_ADDR-1:0]       tb_start_addr_i,
    input  logic [W_LEN-1:0]        tb_len_i,
    input  logic [W_LEN-1:0]        dec_len_i,
    output logic                    busy_o,
    output logic                    start_err_o,
    output logic                    tb_rd_o,
    output logic [W_ADDR-1:0]       tb_addr_o,
    input  logic [(2**W_STATE)-1:0] tb_rdata_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [W_OUT-1:0]        out_data_o,
    output logic [W_CNT-1:0]        out_cnt_o,
    output logic                    out_last_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fsm_t;

    fsm_t               fsm_q;
    fsm_t               fsm_d;

    logic [W_STATE-1:0] state_q;
    logic [W_ABITS-1:0] active_q;
    logic [W_ADDR-1:0]  addr_q;
    logic [W_LEN-1:0]   steps_rem;   // reads still to issue
    logic [W_LEN-1:0]   train_rem;   // training returns still to discard
    logic [W_LEN-1:0]   dec_rem;     // decoded bits still to produce
    logic [W_CNT-1:0]   inflight;
    logic [W_CNT-1:0]   acc_cnt;
    logic [W_OUT-1:0]   acc_data;
    logic [RD_LAT-1:0]  rd_pipe;     // issue strobes travelling with the read latency

    logic               running;
    logic               issue;
    logic               ret;
    logic               xfer;
    logic               accept;
    logic               dec_bit;
    logic [W_STATE-1:0] state_nxt;
    logic [W_LEN-1:0]   eff_dec;
    logic [W_LEN-1:0]   train_len;
    logic [W_CNT:0]     reserved;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    always_comb begin
        running   = (fsm_q == S_RUN);
        accept    = out_valid_o & out_ready_i;
        ret       = rd_pipe[RD_LAT-1];

        eff_dec   = (dec_len_i < tb_len_i) ? dec_len_i : tb_len_i;
        train_len = tb_len_i - eff_dec;

        // Accumulator slots already promised to reads still in flight; this
        // reservation is what keeps the accumulator from ever overflowing.
        reserved  = {1'b0, acc_cnt} + {1'b0, inflight};
        issue     = running && (steps_rem != '0) && (reserved < (W_CNT+1)'(W_OUT));

        dec_bit   = tb_rdata_i[state_q];
        state_nxt = (state_q >> 1) | (W_STATE'(dec_bit) << (active_q - 1'b1));

        // Move a full accumulator, or the tail of the segment, into the
        // output register when that register is free this cycle.
        xfer      = running
                    && ((acc_cnt == W_CNT'(W_OUT)) || ((dec_rem == '0) && (acc_cnt != '0)))
                    && (!out_valid_o || out_ready_i);

        tb_rd_o   = issue;
        tb_addr_o = issue ? addr_q : '0;
        busy_o    = running;

        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE: begin
                if (start_i) begin
                    fsm_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept && out_last_o) begin
                    fsm_d = S_IDLE;
                end else if (ret && (train_rem == W_LEN'(1)) && (dec_rem == '0)) begin
                    // Nothing to decode: finish on the last training return.
                    fsm_d = S_IDLE;
                end else if ((steps_rem == '0) && (train_rem == '0) && (dec_rem == '0)
                             && (inflight == '0) && (acc_cnt == '0) && !out_valid_o) begin
                    // Zero-length segment.
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            fsm_q       <= S_IDLE;
            state_q     <= '0;
            active_q    <= '0;
            addr_q      <= '0;
            steps_rem   <= '0;
            train_rem   <= '0;
            dec_rem     <= '0;
            inflight    <= '0;
            acc_cnt     <= '0;
            acc_data    <= '0;
            rd_pipe     <= '0;
            start_err_o <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_cnt_o   <= '0;
            out_last_o  <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            start_err_o <= start_i & running;
            rd_pipe     <= RD_LAT'({rd_pipe, issue});

            if (!running) begin
                if (start_i) begin
                    state_q   <= start_state_i;
                    active_q  <= active_bits_i;
                    addr_q    <= tb_start_addr_i;
                    steps_rem <= tb_len_i;
                    train_rem <= train_len;
                    dec_rem   <= eff_dec;
                    inflight  <= '0;
                    acc_cnt   <= '0;
                    acc_data  <= '0;
                end
            end else begin
                if (issue) begin
                    addr_q    <= addr_q - W_ADDR'(1);
                    steps_rem <= steps_rem - W_LEN'(1);
                end

                case ({issue, ret})
                    2'b10:   inflight <= inflight + W_CNT'(1);
                    2'b01:   inflight <= inflight - W_CNT'(1);
                    default: inflight <= inflight;
                endcase

                if (ret) begin
                    state_q <= state_nxt;
                    if (train_rem != '0) begin
                        train_rem <= train_rem - W_LEN'(1);
                    end else begin
                        dec_rem  <= dec_rem - W_LEN'(1);
                        acc_data <= acc_data | (W_OUT'(state_q[0]) << acc_cnt);
                        acc_cnt  <= acc_cnt + W_CNT'(1);
                    end
                end

                if (xfer) begin
                    out_valid_o <= 1'b1;
                    out_data_o  <= acc_data;
                    out_cnt_o   <= acc_cnt;
                    out_last_o  <= (dec_rem == '0);
                    acc_cnt     <= '0;
                    acc_data    <= '0;
                end else if (accept) begin
                    out_valid_o <= 1'b0;
                    out_last_o  <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traceback_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_traceback_pipe
// Purpose  : Self-checking bench for traceback_pipe. A decision-memory model
//            answers reads with the configured latency; a reference walk of
//            the trellis fills expected read-address and output-word queues
//            that a monitor drains as the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traceback_pipe;

    localparam int W_STATE = 6;
    localparam int W_ABITS = 3;
    localparam int W_ADDR  = 6;
    localparam int W_LEN   = 7;
    localparam int W_OUT   = 32;
    localparam int W_CNT   = 6;
    localparam int RD_LAT  = 2;
    localparam int NW      = 1 << W_STATE;
    localparam int DEPTH   = 1 << W_ADDR;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [W_STATE-1:0] start_state = '0;
    logic [W_ABITS-1:0] active = '0;
    logic [W_ADDR-1:0]  tb_start_addr = '0;
    logic [W_LEN-1:0]   tb_len = '0;
    logic [W_LEN-1:0]   dec_len = '0;
    logic               busy;
    logic               start_err;
    logic               tb_rd;
    logic [W_ADDR-1:0]  tb_addr;
    logic [NW-1:0]      tb_rdata;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [W_OUT-1:0]   out_data;
    logic [W_CNT-1:0]   out_cnt;
    logic               out_last;

    always #5 clk = ~clk;

    traceback_pipe #(
        .W_STATE(W_STATE), .W_ABITS(W_ABITS), .W_ADDR(W_ADDR), .W_LEN(W_LEN),
        .W_OUT(W_OUT), .W_CNT(W_CNT), .RD_LAT(RD_LAT)
    ) dut (
        .clk_i          (clk),
        .rst_sync_i     (rst),
        .start_i        (start),
        .start_state_i  (start_state),
        .active_bits_i  (active),
        .tb_start_addr_i(tb_start_addr),
        .tb_len_i       (tb_len),
        .dec_len_i      (dec_len),
        .busy_o         (busy),
        .start_err_o    (start_err),
        .tb_rd_o        (tb_rd),
        .tb_addr_o      (tb_addr),
        .tb_rdata_i     (tb_rdata),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data),
        .out_cnt_o      (out_cnt),
        .out_last_o     (out_last)
    );

    // ------------------------------------------------------------------------
    // Decision memory model with RD_LAT cycles of read latency
    // ------------------------------------------------------------------------
    logic [NW-1:0]     mem [DEPTH];
    logic [W_ADDR-1:0] apipe [RD_LAT];
    logic              vpipe [RD_LAT];
    logic [NW-1:0]     garbage = '0;

    initial begin
        for (int i = 0; i < RD_LAT; i++) begin
            apipe[i] = '0;
            vpipe[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) begin
            apipe[i] <= apipe[i-1];
            vpipe[i] <= vpipe[i-1];
        end
        apipe[0] <= tb_addr;
        vpipe[0] <= tb_rd;
        garbage  <= {$urandom, $urandom};
    end

    assign tb_rdata = vpipe[RD_LAT-1] ? mem[apipe[RD_LAT-1]] : garbage;

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [W_OUT-1:0] data;
        logic [W_CNT-1:0] cnt;
        logic             last;
    } word_t;

    word_t             exp_q[$];
    logic [W_ADDR-1:0] addr_q[$];
    int                n_vec = 0;
    int                n_err = 0;
    int                ready_mode = 0;   // 0: always ready, 1: random, 2: held low

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        n_vec++;
        n_err++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Reference: walk the trellis straight from the decoding rules.
    task automatic model(input int st, input int act, input int addr, input int tlen, input int dlen);
        int    eff;
        int    train;
        int    s;
        int    a;
        int    d;
        int    b;
        int    bits[$];
        word_t w;
        eff   = (dlen < tlen) ? dlen : tlen;
        train = tlen - eff;
        s     = st;
        a     = addr;
        for (int i = 0; i < tlen; i++) begin
            addr_q.push_back(a[W_ADDR-1:0]);
            d = int'(mem[a][s]);
            if (i >= train) bits.push_back(s % 2);
            s = (s / 2) + d * (1 << (act - 1));
            a = (a + DEPTH - 1) % DEPTH;
        end
        while (bits.size() > 0) begin
            w = '0;
            for (int k = 0; k < W_OUT; k++) begin
                if (bits.size() > 0) begin
                    b         = bits.pop_front();
                    w.data[k] = b[0];
                    w.cnt     = w.cnt + 1'b1;
                end
            end
            w.last = (bits.size() == 0);
            exp_q.push_back(w);
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < DEPTH; i++) begin
            case (mode)
                0:       mem[i] = '0;
                1:       mem[i] = '1;
                default: mem[i] = {$urandom, $urandom};
            endcase
        end
    endtask

    // Pulse start with the given configuration, then scramble the config
    // inputs so that only latched values can be in use.
    task automatic start_seg(input int st, input int act, input int addr, input int tlen, input int dlen);
        model(st, act, addr, tlen, dlen);
        @(posedge clk); #1;
        start         = 1'b1;
        start_state   = st[W_STATE-1:0];
        active        = act[W_ABITS-1:0];
        tb_start_addr = addr[W_ADDR-1:0];
        tb_len        = tlen[W_LEN-1:0];
        dec_len       = dlen[W_LEN-1:0];
        @(posedge clk); #1;
        start         = 1'b0;
        start_state   = W_STATE'($urandom);
        active        = W_ABITS'($urandom);
        tb_start_addr = W_ADDR'($urandom);
        tb_len        = W_LEN'($urandom);
        dec_len       = W_LEN'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, 64'(busy), 64'(0));
        check({name, "_words_left"}, 64'(exp_q.size()), 64'(0));
        check({name, "_reads_left"}, 64'(addr_q.size()), 64'(0));
        repeat (RD_LAT + 2) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        check({name, "_busy"}, 64'(busy), 64'(0));
        check({name, "_rd"}, 64'(tb_rd), 64'(0));
        check({name, "_addr"}, 64'(tb_addr), 64'(0));
        check({name, "_err"}, 64'(start_err), 64'(0));
        check({name, "_outs"}, 64'({out_valid, out_data, out_cnt, out_last}), 64'(0));
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    logic  idle_chk = 1'b0;
    logic  prev_stall = 1'b0;
    word_t prev_w = '0;
    word_t exp_w;

    always @(negedge clk) begin
        if (rst) begin
            idle_chk   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (idle_chk) begin
                check("busy_after_last", 64'(busy), 64'(0));
                idle_chk = 1'b0;
            end
            if (tb_rd) begin
                if (addr_q.size() == 0) flag("rd_unexpected", "read strobe with no read expected");
                else check("rd_addr", 64'(tb_addr), 64'(addr_q.pop_front()));
            end
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_word", 64'({out_data, out_cnt, out_last}), 64'(prev_w));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    flag("out_unexpected", "output word with none expected");
                end else begin
                    exp_w = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(exp_w.data));
                    check("out_cnt", 64'(out_cnt), 64'(exp_w.cnt));
                    check("out_last", 64'(out_last), 64'(exp_w.last));
                    if (out_last) idle_chk = 1'b1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_w     = {out_data, out_cnt, out_last};
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int act;
        int st;
        fill(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // All-zero decisions, 40 steps / 32 decoded, back-to-back reads.
        ready_mode = 0;
        fill(0);
        start_seg(0, 6, 17, 40, 32);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("rd_back_to_back", 64'(tb_rd), 64'(1));
        end
        @(negedge clk);
        check("rd_stop_after_40", 64'(tb_rd), 64'(0));
        wait_idle("zeros40");

        // All-one decisions, 3 active bits: expect 0xF8.
        fill(1);
        start_seg(0, 3, 9, 8, 8);
        wait_idle("ones8");

        // Address wrap below zero.
        fill(2);
        start_seg(5, 6, 2, 5, 5);
        wait_idle("wrap5");

        // Long backpressure: reads must stall, three words 32/32/6.
        fill(2);
        ready_mode = 2;
        start_seg(13, 6, 40, 70, 70);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("stall_rd", 64'(tb_rd), 64'(0));
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_cnt", 64'(out_cnt), 64'(32));
        check("stall_busy", 64'(busy), 64'(1));
        ready_mode = 0;
        wait_idle("bp70");

        // Zero-length segment: busy exactly one cycle.
        start_seg(0, 6, 0, 0, 0);
        @(negedge clk);
        check("len0_busy_hi", 64'(busy), 64'(1));
        @(negedge clk);
        check("len0_busy_lo", 64'(busy), 64'(0));
        wait_idle("len0");

        // dec_len larger than tb_len.
        fill(2);
        start_seg(3, 4, 30, 6, 10);
        wait_idle("dec_gt_tb");

        // Training only.
        fill(2);
        ready_mode = 1;
        start_seg(7, 5, 11, 12, 0);
        wait_idle("train_only");

        // Start while busy.
        fill(2);
        start_seg(21, 6, 50, 100, 90);
        repeat (5) @(posedge clk);
        #1;
        start       = 1'b1;
        start_state = 6'd1;
        tb_len      = 7'd3;
        @(posedge clk); #1;
        start       = 1'b0;
        @(negedge clk);
        check("start_err_pulse", 64'(start_err), 64'(1));
        @(negedge clk);
        check("start_err_clear", 64'(start_err), 64'(0));
        wait_idle("start_busy");

        // Reset in the middle of a segment.
        fill(2);
        start_seg(9, 6, 20, 60, 50);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        addr_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("midreset");
        repeat (4) @(negedge clk);
        check("midreset_quiet", 64'({busy, tb_rd, out_valid}), 64'(0));
        fill(2);
        start_seg(2, 6, 33, 45, 40);
        wait_idle("after_reset");

        // Random segments.
        for (int n = 0; n < 12; n++) begin
            act = $urandom_range(2, W_STATE);
            st  = $urandom_range(0, (1 << act) - 1);
            fill(2);
            start_seg(st, act, $urandom_range(0, DEPTH - 1), $urandom_range(0, 127), $urandom_range(0, 127));
            wait_idle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traceback_pipe.md
Name: traceback_pipe

Overview:
- Next-generation Viterbi traceback unit. It reads decision words from the survivor (decision) memory, walks the trellis backwards from a given start state, discards the training steps, and emits decoded bits as packed words over a valid/ready stream.
- Generalised from the previous unit in four ways: state width is a parameter, constraint length is selectable at run time, memory read latency is a parameter, and reads are fully pipelined at one trellis step per cycle.
- Sits between the ACS/decision-memory write side and the output bit packer.

Parameters:
W_STATE, 6, state index width; decision word width is 2^W_STATE.
W_ABITS, 3, width of active_bits_i.
W_ADDR, 6, decision memory address width.
W_LEN, 7, width of tb_len_i and dec_len_i.
W_OUT, 32, output word width.
W_CNT, 6, width of out_cnt_o; must hold values up to W_OUT.
RD_LAT, 1, decision memory read latency in cycles; legal range 1..3.

Ports:
clk_i  in  1  clock.
rst_sync_i  in  1  reset; synchronous, active-high.
start_i  in  1  segment start pulse; sampled only when idle.
start_state_i  in  W_STATE  traceback start state.
active_bits_i  in  W_ABITS  active state bits; legal range 2..W_STATE.
tb_start_addr_i  in  W_ADDR  address of the newest decision word.
tb_len_i  in  W_LEN  total traceback steps.
dec_len_i  in  W_LEN  decoded (output) steps; these are the last dec_len steps of the walk.
busy_o  out  1  segment in progress.
start_err_o  out  1  one-cycle pulse: start_i arrived while busy.
tb_rd_o  out  1  decision memory read strobe.
tb_addr_o  out  W_ADDR  read address.
tb_rdata_i  in  2^W_STATE  decision word; valid RD_LAT cycles after the matching tb_rd_o.
out_valid_o  out  1  output word valid.
out_ready_i  in  1  downstream accept.
out_data_o  out  W_OUT  decoded bits; bit j is the j-th produced bit.
out_cnt_o  out  W_CNT  number of valid bits in out_data_o (1..W_OUT).
out_last_o  out  1  final word of the segment.

Behaviour:
- Reset: all outputs 0; state register 0; step counter 0; in-flight counter 0; accumulator empty. The read-return valid pipeline is cleared, so data returning after a reset is ignored.
- Reset mid-segment aborts the segment. No partial word is emitted.
- Start, idle only:
  - Latch all configuration inputs. Load state = start_state_i and addr = tb_start_addr_i.
  - steps = tb_len_i. eff_dec = min(dec_len_i, tb_len_i). train = steps - eff_dec.
  - busy_o rises the next cycle.
- Start while busy: ignored; start_err_o pulses for 1 cycle.
- Read issue:
  - A read is issued in a cycle when remaining steps > 0 and acc_cnt + inflight < W_OUT.
  - On issue: tb_rd_o=1, tb_addr_o = current addr; addr then decrements modulo 2^W_ADDR (0 wraps to 2^W_ADDR-1).
  - The first read can occur the cycle after start, giving one step per cycle when there is no backpressure.
- Read return, consumed exactly RD_LAT cycles after issue:
  - d = tb_rdata_i[state].
  - Produced bit = state[0], taken before the update.
  - Update: state = (state >> 1) | (d << (active_bits-1)). Only the low active_bits bits are meaningful; upper bits stay 0 if start_state is within range.
  - Returns 1..train are training: the state is updated, no bit is produced.
  - The remaining returns shift the produced bit into accumulator position acc_cnt, then acc_cnt increments.
- Accumulator to output:
  - Transfer when acc_cnt == W_OUT, or when the segment's final bit has been accumulated. The transfer requires the output register to be empty, or accepted in the same cycle.
  - Transfer sets out_valid_o, out_cnt_o = acc_cnt, out_last_o on the final word, and resets acc_cnt to 0.
  - Unused upper bits of out_data_o are 0.
- Output hold: out_valid_o, out_data_o, out_cnt_o and out_last_o stay stable until out_ready_i; a transfer completes when valid and ready are both high.
- Accumulator overflow is impossible because the issue rule reserves space for in-flight reads.
- busy_o falls the cycle after the out_last word is accepted.
- If eff_dec == 0: busy_o falls the cycle after the last read returns; no output word.
- If tb_len_i == 0: busy_o is high for exactly 1 cycle, with no reads and no output.
- Undefined and unchecked: active_bits_i outside the legal range, or RD_LAT > 3.

Test Plan:
- W_STATE=6, RD_LAT=1, active=6, start_state=0, tb_len=40, dec_len=32, all decision words 0, out_ready=1.
  - 40 reads on consecutive cycles, addresses tb_start_addr, tb_start_addr-1, and so on.
  - One word: out_data=0, out_cnt=32, out_last=1.
- Decision words all 1s, active=3, start_state=0, tb_len=8, dec_len=8.
  - State sequence 0,4,6,7,7,...
  - Produced bits 0,0,0,1,1,1,1,1, so out_data=0xF8 and out_cnt=8.
- tb_start_addr=2, tb_len=5, RD_LAT=3.
  - Addresses 2,1,0,63,62 issued back-to-back.
  - Decoded output identical to the same case with RD_LAT=1.
- dec_len=70, tb_len=70, out_ready held low for 20 cycles.
  - Reads stall; words emitted with cnt=32, 32, 6 and last only on the third word.
  - No bit is lost or duplicated.
- tb_len=0 -> busy for 1 cycle, no tb_rd_o, no output.
- dec_len=10 > tb_len=6 -> 6 bits output.
- start_i pulsed while busy -> start_err_o pulses, the segment is unaffected.
- rst_sync_i asserted mid-segment with RD_LAT=2 -> next cycle all outputs are 0 and late read returns are ignored; a new start_i then decodes correctly.
